// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: registered command front-end for the 32-bit unsigned ALU.
// Ports: cmd_* in (valid/ready), alu_* drive/return, rsp_* out (valid/ready),
// carry_q chain carry. SETTLE_CYCLES (1..15) sets the hold before capture.
// Define ALU_DRV_STATS_EN to add the stat_cmds / stat_carries counters.
module alu_cmd_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_cin,
  input  logic        cmd_chain,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_cout,
  output logic [2:0]  rsp_op,
  output logic        carry_q
`ifdef ALU_DRV_STATS_EN
  ,
  output logic [15:0] stat_cmds,
  output logic [15:0] stat_carries
`endif
);

  localparam logic [2:0] OP_ADD = 3'b111;
  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       accept;
  logic       capture;

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign capture = (state_q == SETTLE) && (cnt_q == LAST);

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = SETTLE;
      SETTLE:  if (capture) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == SETTLE && !capture) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // ALU drive is held from accept until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
    end else if (accept) begin
      alu_opcode <= cmd_op;
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
      alu_cin    <= cmd_chain ? carry_q : cmd_cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_op     <= '0;
      carry_q    <= 1'b0;
    end else if (capture) begin
      rsp_result <= alu_result;
      rsp_cout   <= alu_cout;
      rsp_op     <= alu_opcode;
      if (alu_opcode == OP_ADD) carry_q <= alu_cout;
    end
  end

`ifdef ALU_DRV_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cmds    <= '0;
      stat_carries <= '0;
    end else begin
      if (accept && stat_cmds != 16'hFFFF) begin
        stat_cmds <= stat_cmds + 16'd1;
      end
      if (capture && alu_opcode == OP_ADD && alu_cout &&
          stat_carries != 16'hFFFF) begin
        stat_carries <= stat_carries + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Sequential command front-end for the 32-bit unsigned ALU (`alu_32bit_unsigned`).
- Accepts operation commands over a valid/ready handshake and drives the ALU's `opcode`/`a`/`b`/`cin` inputs from registers.
- Waits a programmable settle interval, captures `result`/`cout` and returns them over a second valid/ready handshake.
- Keeps a carry register so multi-word additions can chain carry between commands.
- Sits between the control logic (or a bench initiator) and the combinational ALU.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: driver can accept a command.
- `cmd_op` in 3: ALU opcode. NOT=000, AND=001, OR=010, XOR=011, SHL=100, SHR=101, CUT=110, ADD=111.
- `cmd_a` in 32, `cmd_b` in 32: operands.
- `cmd_cin` in 1: explicit carry-in.
- `cmd_chain` in 1: 1 selects the stored carry as carry-in instead of `cmd_cin`.
- `alu_opcode` out 3, `alu_a` out 32, `alu_b` out 32, `alu_cin` out 1: registered drive to the ALU.
- `alu_result` in 32, `alu_cout` in 1: ALU outputs.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_result` out 32, `rsp_cout` out 1, `rsp_op` out 3: captured response.
- `carry_q` out 1: stored chain carry.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`: load the `alu_*` registers and go to SETTLE.
    - Effective cin = `cmd_chain` ? `carry_q` : `cmd_cin`.
  - SETTLE: settle counter runs from 0. When it reaches SETTLE_CYCLES-1:
    - Capture `alu_result`→`rsp_result`, `alu_cout`→`rsp_cout`, opcode→`rsp_op`.
    - Go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`: go to IDLE.
- `cmd_ready` is high only in IDLE and is decoded from state. There is no command/response overlap: one command is in flight at a time.
- `carry_q` is updated at capture only when opcode is ADD (loads `alu_cout`). All other ops leave it unchanged.
- `alu_*` registers hold the last command after completion. They change only on command accept.
- `rsp_*` data is stable while `rsp_valid`=1 and changes only at capture.
- The driver does not interpret operand values. Shift amounts, CUT widths and the 32-bit wrap of ADD are whatever the ALU returns.
- Reset (any state, including mid-SETTLE or RESP):
  - FSM returns to IDLE and the counter clears.
  - All outputs go to 0, except `cmd_ready`, which is 1 once in IDLE.
  - An in-flight command is dropped with no response.

## Timing
- Accept at edge N: `alu_*` valid from N. Capture at edge N+SETTLE_CYCLES. `rsp_valid` high from that edge.
- Accept-to-`rsp_valid` latency is SETTLE_CYCLES+1 cycles, counting the accept cycle.
- If `rsp_ready` is already high when `rsp_valid` rises, the handshake completes in one cycle. The next command can be accepted on the following cycle.
- Throughput is at most one command per SETTLE_CYCLES+2 cycles.
- `cmd_valid` seen outside IDLE is ignored. The initiator must hold `cmd_valid` and its data until `cmd_ready`.

## Configuration
- `ALU_DRV_STATS_EN` defined: adds two outputs.
  - `stat_cmds` out 16: increments on each command accept and saturates at 0xFFFF.
  - `stat_carries` out 16: increments on each ADD capture with `alu_cout`=1 and saturates.
  - Both reset to 0.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- ADD a=0xFFFFFFFF, b=1, cin=0, chain=0 → `rsp_result`=0x00000000, `rsp_cout`=1, `carry_q`=1. Then ADD a=0, b=0, chain=1 → `rsp_result`=0x00000001, `rsp_cout`=0, `carry_q`=0.
- With `carry_q`=1, send NOT a=0x12345678 → `rsp_result`=0xEDCBA987, `rsp_op`=000, `carry_q` stays 1.
- SETTLE_CYCLES=3, accept at cycle 10 → `rsp_valid` first high at cycle 14. Hold `rsp_ready`=0 for 5 cycles → `rsp_*` unchanged and `cmd_ready`=0 throughout.
- CUT a=0x12345678, b=8 → `rsp_result`=0x00000078. SHL a=0x80000000, b=1 → `rsp_result`=0, `carry_q` unchanged.
- Assert `rst_n`=0 during SETTLE of an ADD → no `rsp_valid`. All outputs 0, `cmd_ready`=1 after release, `carry_q`=0.
- With `ALU_DRV_STATS_EN`: 4 commands including one carrying ADD → `stat_cmds`=4, `stat_carries`=1.
